// File: rtl/mem_port_arbiter_if.sv
// Bundle of all signals around the shared memory port: the fetch and
// load/store requester handshakes, the common response bus, the memory-side
// handshake and the busy status.
// The master view belongs to the arbiter. The slave view belongs to everything
// around it: both requesters and the memory.
interface mem_port_arbiter_if #(
    parameter int WIDTH = 32
);
    // fetch requester
    logic             if_req;
    logic [WIDTH-1:0] if_addr;
    logic             if_ack;

    // load/store requester
    logic             ls_req;
    logic             ls_we;
    logic [3:0]       ls_be;
    logic [WIDTH-1:0] ls_addr;
    logic [WIDTH-1:0] ls_wdata;
    logic             ls_ack;

    // shared response, valid in the ack cycle
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_err;

    // memory side
    logic             mem_req;
    logic             mem_we;
    logic [3:0]       mem_be;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ready;
    logic [WIDTH-1:0] mem_rdata;

    logic             busy;

    modport master (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        output if_ack, ls_ack, rsp_rdata, rsp_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata,
        output busy
    );

    modport slave (
        output if_req, if_addr,
        output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        input  if_ack, ls_ack, rsp_rdata, rsp_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ready, mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Only one access is in flight at a time. Load/store normally wins
// arbitration. Fetch is forced through after STARVE_LIMIT consecutive losses.
// A watchdog ends any access that waits TIMEOUT cycles for mem_ready, and
// returns an error response.
module mem_port_arbiter #(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    // A disabled watchdog still gets a 1-bit counter so the declaration stays legal.
    localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t            state;
    state_t            state_nxt;
    logic              owner_ls;      // 1: load/store owns the current access
    logic [SC_W-1:0]   starve_cnt;
    logic [TO_W-1:0]   to_cnt;        // ACCESS cycles already spent without mem_ready
    logic              pick_if;
    logic              pick_ls;
    logic              to_hit;
    logic              both_req;

    assign both_req = bus.if_req & bus.ls_req;

    // Watchdog fires in the TIMEOUT-th ACCESS cycle. mem_ready is checked
    // before it, so a ready in that same cycle still completes normally.
    generate
        if (TIMEOUT > 0) begin : g_wdog
            assign to_hit = (to_cnt == TO_W'(TIMEOUT - 1));
        end else begin : g_no_wdog
            assign to_hit = 1'b0;
        end
    endgenerate

    // Arbitration: a single requester wins. On a tie, load/store wins unless
    // fetch has lost STARVE_LIMIT times in a row.
    always_comb begin
        pick_if = 1'b0;
        pick_ls = 1'b0;
        if (both_req) begin
            if (starve_cnt == SC_W'(STARVE_LIMIT)) pick_if = 1'b1;
            else                                   pick_ls = 1'b1;
        end else if (bus.if_req) begin
            pick_if = 1'b1;
        end else if (bus.ls_req) begin
            pick_ls = 1'b1;
        end
    end

    // Next-state logic. Requests are looked at only in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_if || pick_ls)        state_nxt = ACCESS;
            ACCESS:  if (bus.mem_ready || to_hit)   state_nxt = RESP;
            RESP:                                   state_nxt = IDLE;
            default:                                state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Busy is registered from the next state so that it lines up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.busy <= 1'b0;
        else     bus.busy <= (state_nxt != IDLE);
    end

    // Starvation counter: counts ties that fetch lost, and clears on any fetch grant.
    // A tie can only go to load/store below the limit, so the +1 never
    // passes STARVE_LIMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (pick_if)                   starve_cnt <= '0;
            else if (pick_ls && both_req)  starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    // Watchdog counter: zero outside ACCESS, counts up while waiting for mem_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state == ACCESS && TIMEOUT > 0 && !bus.mem_ready && !to_hit) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else if (state != ACCESS) begin
            to_cnt <= '0;
        end
    end

    // Memory request side: latch the winner on grant, and hold every mem_*
    // output stable until the access completes or times out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= 4'b0000;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            owner_ls      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_if) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_be    <= 4'b1111;
                        bus.mem_addr  <= bus.if_addr;
                        bus.mem_wdata <= '0;
                        owner_ls      <= 1'b0;
                    end else if (pick_ls) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= bus.ls_we;
                        bus.mem_be    <= bus.ls_be;
                        bus.mem_addr  <= bus.ls_addr;
                        bus.mem_wdata <= bus.ls_wdata;
                        owner_ls      <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (bus.mem_ready || to_hit) bus.mem_req <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Response side: capture read data or the timeout error, then send a
    // one-cycle ack to whichever requester owns the access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.if_ack    <= 1'b0;
            bus.ls_ack    <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.if_ack <= 1'b0;
            bus.ls_ack <= 1'b0;
            if (state == ACCESS) begin
                if (bus.mem_ready) begin
                    bus.rsp_rdata <= bus.mem_rdata;
                    bus.rsp_err   <= 1'b0;
                    bus.if_ack    <= ~owner_ls;
                    bus.ls_ack    <= owner_ls;
                end else if (to_hit) begin
                    bus.rsp_rdata <= '0;
                    bus.rsp_err   <= 1'b1;
                    bus.if_ack    <= ~owner_ls;
                    bus.ls_ack    <= owner_ls;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. It runs a table of single transactions,
// hand-written sequences for starvation, reset during an access and a request
// held through its ack, and then randomized traffic that is checked against a
// transaction-level model.
module tb_mem_port_arbiter;

    localparam int W     = 32;
    localparam int LIMIT = 4;
    localparam int TO    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    mem_port_arbiter_if #(.WIDTH(W)) bus ();

    mem_port_arbiter #(.WIDTH(W), .STARVE_LIMIT(LIMIT), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Runs one transaction. The task is entered in an IDLE cycle and returns
    // in the IDLE cycle after the ack. w is the ACCESS cycle index at which
    // mem_ready is raised; an index at or beyond TO never raises it, so the
    // watchdog must end the access.
    task automatic run_txn(input bit ifr, input bit lsr, input logic [31:0] ia,
                           input bit we, input logic [3:0] be, input logic [31:0] la,
                           input logic [31:0] wd, input int w, input logic [31:0] rd,
                           input bit exp_if, input bit exp_err, input logic [31:0] exp_rd);
        logic [31:0] ea;
        ea = exp_if ? ia : la;
        bus.if_req = ifr; bus.if_addr = ia;
        bus.ls_req = lsr; bus.ls_we = we; bus.ls_be = be; bus.ls_addr = la; bus.ls_wdata = wd;
        bus.mem_ready = 1'b0;
        step();
        chk("grant_mem_req", bus.mem_req, 1);
        chk("grant_busy",    bus.busy, 1);
        chk("grant_addr",    bus.mem_addr, ea);
        chk("grant_we",      bus.mem_we, exp_if ? 1'b0 : we);
        chk("grant_be",      bus.mem_be, exp_if ? 4'hF : be);
        if (!exp_if) chk("grant_wdata", bus.mem_wdata, wd);
        for (int k = 0; k < TO; k++) begin
            bus.mem_ready = (k == w);
            bus.mem_rdata = (k == w) ? rd : $urandom;
            step();
            if (k == w || k == TO - 1) break;
            chk("access_mem_req", bus.mem_req, 1);
            chk("access_addr",    bus.mem_addr, ea);
            chk("access_acks",    {bus.if_ack, bus.ls_ack}, 0);
        end
        bus.mem_ready = 1'b0;
        chk("resp_if_ack",  bus.if_ack, exp_if);
        chk("resp_ls_ack",  bus.ls_ack, !exp_if);
        chk("resp_err",     bus.rsp_err, exp_err);
        chk("resp_rdata",   bus.rsp_rdata, exp_rd);
        chk("resp_mem_req", bus.mem_req, 0);
        step();
        chk("idle_acks",    {bus.if_ack, bus.ls_ack}, 0);
        chk("idle_busy",    bus.busy, 0);
        chk("idle_mem_req", bus.mem_req, 0);
    endtask

    typedef struct {
        bit          ifr, lsr, we;
        logic [3:0]  be;
        logic [31:0] ia, la, wd;
        int          w;
        logic [31:0] rd;
        bit          exp_if, exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[7];

    // random-phase model state
    int          starve;
    bit          if_pend, ls_pend, win_if, both, err;
    logic [31:0] r_ia, r_la, r_wd, r_rd;
    logic [3:0]  r_be;
    bit          r_we;
    int          r_w;

    initial begin
        //          ifr lsr we be     ia       la        wd            w   rd            if err rdata
        vecs[0] = '{1, 0, 0, 4'h0, 32'h100, 32'h0,    32'h0,        0,  32'hDEADBEEF, 1, 0, 32'hDEADBEEF};
        vecs[1] = '{0, 1, 1, 4'h3, 32'h0,   32'h2000, 32'h12345678, 2,  32'hA5A5A5A5, 0, 0, 32'hA5A5A5A5};
        vecs[2] = '{0, 1, 0, 4'hF, 32'h0,   32'h44,   32'h0,        1,  32'h0BADF00D, 0, 0, 32'h0BADF00D};
        vecs[3] = '{1, 1, 0, 4'hF, 32'h300, 32'h48,   32'h0,        0,  32'h11112222, 0, 0, 32'h11112222};
        vecs[4] = '{1, 0, 0, 4'h0, 32'h300, 32'h0,    32'h0,        99, 32'h55555555, 1, 1, 32'h0};
        vecs[5] = '{0, 1, 0, 4'hC, 32'h0,   32'h80,   32'h0,        15, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D};
        vecs[6] = '{1, 1, 1, 4'h1, 32'h400, 32'h84,   32'h77,       3,  32'h33334444, 0, 0, 32'h33334444};

        bus.if_req = 0; bus.if_addr = '0; bus.ls_req = 0; bus.ls_we = 0; bus.ls_be = '0;
        bus.ls_addr = '0; bus.ls_wdata = '0; bus.mem_ready = 0; bus.mem_rdata = '0;

        // reset state
        do_reset();
        chk("rst_mem_req",  bus.mem_req, 0);
        chk("rst_mem_we",   bus.mem_we, 0);
        chk("rst_mem_be",   bus.mem_be, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_wdata",    bus.mem_wdata, 0);
        chk("rst_acks",     {bus.if_ack, bus.ls_ack}, 0);
        chk("rst_rsp",      {bus.rsp_err, bus.rsp_rdata}, 0);
        chk("rst_busy",     bus.busy, 0);
        step();
        chk("idle_no_req_mem_req", bus.mem_req, 0);

        // table-driven vectors
        foreach (vecs[i])
            run_txn(vecs[i].ifr, vecs[i].lsr, vecs[i].ia, vecs[i].we, vecs[i].be, vecs[i].la,
                    vecs[i].wd, vecs[i].w, vecs[i].rd, vecs[i].exp_if, vecs[i].exp_err, vecs[i].exp_rd);

        // starvation: both requesters held, so the grants follow ls x4, then if, and repeat
        do_reset();
        for (int i = 0; i < 10; i++)
            run_txn(1, 1, 32'h1000 + i, 0, 4'hF, 32'h2000 + i, 32'h0, 0, 32'h900 + i,
                    (i % 5) == 4, 0, 32'h900 + i);

        // reset pulsed in the middle of ACCESS
        bus.ls_req = 0; bus.if_req = 1; bus.if_addr = 32'h500; bus.mem_ready = 0;
        step();
        chk("pre_rst_mem_req", bus.mem_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_mem_req", bus.mem_req, 0);
        chk("async_rst_busy",    bus.busy, 0);
        step();
        chk("in_rst_acks", {bus.if_ack, bus.ls_ack}, 0);
        step();
        chk("in_rst_acks2", {bus.if_ack, bus.ls_ack}, 0);
        rst = 1'b0;
        run_txn(1, 0, 32'h500, 0, 4'h0, 32'h0, 32'h0, 1, 32'h600DF00D, 1, 0, 32'h600DF00D);

        // request held through its ack and one cycle beyond: a second grant follows
        run_txn(0, 1, 32'h0, 0, 4'hF, 32'h700, 32'h0, 0, 32'h1, 0, 0, 32'h1);
        run_txn(0, 1, 32'h0, 0, 4'hF, 32'h700, 32'h0, 0, 32'h2, 0, 0, 32'h2);
        bus.ls_req = 0;

        // randomized traffic checked against a transaction-level model
        do_reset();
        starve = 0; if_pend = 0; ls_pend = 0;
        for (int t = 0; t < 60; t++) begin
            if (!if_pend && !ls_pend && ($urandom_range(0, 3) == 0)) begin
                bus.if_req = 0; bus.ls_req = 0;
                step();
                chk("rnd_idle_mem_req", bus.mem_req, 0);
                chk("rnd_idle_busy",    bus.busy, 0);
            end
            if (!if_pend && $urandom_range(0, 1) == 1) begin
                if_pend = 1; r_ia = $urandom;
            end
            if (!ls_pend && $urandom_range(0, 1) == 1) begin
                ls_pend = 1; r_la = $urandom; r_wd = $urandom;
                r_we = 1'($urandom); r_be = 4'($urandom);
            end
            if (!if_pend && !ls_pend) begin
                if_pend = 1; r_ia = $urandom;
            end
            both   = if_pend && ls_pend;
            win_if = both ? (starve == LIMIT) : if_pend;
            if (win_if)    starve = 0;
            else if (both) starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
            r_w  = $urandom_range(0, 20);
            r_rd = $urandom;
            err  = (r_w >= TO);
            run_txn(if_pend, ls_pend, r_ia, r_we, r_be, r_la, r_wd, r_w, r_rd,
                    win_if, err, err ? 32'h0 : r_rd);
            if (win_if) if_pend = 0;
            else        ls_pend = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
